// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register write tracking between ID and EX.
// Each architectural register x1..x31 carries a busy flag, a kind (ALU or
// load) and a small countdown. ALU writes retire after a fixed latency, load
// writes retire on their writeback handshake. ID is stalled on RAW/WAW
// conflicts against the registered state only (no same-cycle bypass).
module hazard_scoreboard #(
  parameter int          REG_ADDR_WIDTH = 5,
  parameter int          NUM_REGS       = 32,
  parameter int          ALU_LAT        = 2,
  parameter logic [63:0] RESET_PC       = 64'h8000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [63:0]               id_pc,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic                      id_rs1_en,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs2_en,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_rd_we,
  input  logic                      id_is_load,
  input  logic                      ex_ready,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic                      flush,
  output logic                      stall_id,
  output logic                      issue_fire,
  output logic [NUM_REGS-1:0]       busy_mask,
  output logic [5:0]                pending_cnt
);

  // Countdown start value; ALU_LAT is limited to 1..3 so two bits suffice.
  localparam logic [1:0] ALU_CNT = 2'(ALU_LAT);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] kind_ld_q;   // 1 = load (cleared by WB), 0 = ALU
  logic [1:0]          cnt_q [NUM_REGS];

  logic bubble;
  logic raw;
  logic waw;
  logic alloc;

  function automatic logic [5:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  // Hazard detection and issue decision from registered state only.
  always_comb begin
    bubble     = ~id_valid | (id_pc == 64'd0) | (id_pc == RESET_PC);
    raw        = (id_rs1_en & busy_q[id_rs1]) | (id_rs2_en & busy_q[id_rs2]);
    waw        = id_rd_we & busy_q[id_rd];
    stall_id   = ~bubble & (raw | waw | ~ex_ready);
    issue_fire = ~bubble & ~raw & ~waw & ex_ready & ~flush;
    alloc      = issue_fire & id_rd_we & (id_rd != '0);
  end

  // Per-register tracking: allocate on issue, retire by countdown or WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      kind_ld_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= 2'd0;
    end else if (flush) begin
      // Redirect kills every in-flight write, overriding WB and countdowns.
      busy_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= 2'd0;
    end else begin
      // x0 is never allocated, so its entry stays clear from reset.
      for (int r = 1; r < NUM_REGS; r++) begin
        if (alloc && (id_rd == REG_ADDR_WIDTH'(r))) begin
          busy_q[r]    <= 1'b1;
          kind_ld_q[r] <= id_is_load;
          cnt_q[r]     <= id_is_load ? 2'd0 : ALU_CNT;
        end else if (busy_q[r]) begin
          if (!kind_ld_q[r]) begin
            if (cnt_q[r] == 2'd1) busy_q[r] <= 1'b0;
            cnt_q[r] <= cnt_q[r] - 2'd1;
          end else if (wb_valid && (wb_addr == REG_ADDR_WIDTH'(r))) begin
            busy_q[r] <= 1'b0;
          end
        end
      end
    end
  end

  // Observation views of the registered state.
  always_comb begin
    busy_mask   = busy_q;
    pending_cnt = popcount(busy_q);
  end

endmodule
